output_reorder: RTL and testbench

- Streaming bit-reversal reorder buffer for the FFT output side.
- The FFT emits each N-point frame serially in bit-reversed index order. This block buffers one frame in a ping-pong pair of N-entry `complex_t` banks and replays it in natural order 0..N-1.
- It uses a valid/ready handshake on both sides and sits between the FFT core and the demapper/equalizer.

---
 rtl/output_reorder.sv | 158 +++++++++++++++
 tb/tb_output_reorder.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_reorder.sv
// output_reorder: ping-pong bit-reversal reorder buffer for the FFT output.
// Accepts one N-point frame in bit-reversed order, replays it in natural order.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (registered state only)
//   in_data    complex sample, bit-reversed order
//   in_last    final beat of a frame (framing check only)
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_data   natural-order sample (0 when out_valid is low)
//   out_index  natural index of out_data
//   out_last   high with out_index == N-1
//   frame_err  sticky framing error, cleared only by reset

package output_reorder_pkg;

    parameter int DW = 16;

    typedef struct packed {
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
    } complex_t;

endpackage

module output_reorder
    import output_reorder_pkg::*;
#(
    parameter  int N     = 16,
    localparam int LOG2N = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  complex_t         in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output complex_t         out_data,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last,
    output logic             frame_err
);

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    // Sample storage, intentionally not reset.
    complex_t mem_q [2][N];

    logic [1:0]       full_q;
    logic [1:0]       full_d;
    logic             wr_bank_q;
    logic             wr_bank_d;
    logic             rd_bank_q;
    logic             rd_bank_d;
    logic [LOG2N-1:0] wr_cnt_q;
    logic [LOG2N-1:0] wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q;
    logic [LOG2N-1:0] rd_cnt_d;
    logic             frame_err_q;
    logic             frame_err_d;

    logic             in_fire;
    logic             out_fire;
    logic             wr_wrap;
    logic             rd_wrap;
    logic             wr_is_last;
    logic [LOG2N-1:0] wr_addr;

    function automatic logic [LOG2N-1:0] bitrev(
        input logic [LOG2N-1:0] x
    );
        logic [LOG2N-1:0] y;
        for (int b = 0; b < LOG2N; b++) begin
            y[b] = x[LOG2N-1-b];
        end
        return y;
    endfunction

    // Handshake flags come from registers only, so neither side
    // depends combinationally on the opposite port.
    assign in_ready   = ~full_q[wr_bank_q];
    assign out_valid  = full_q[rd_bank_q];

    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign wr_is_last = (wr_cnt_q == LAST);
    assign wr_wrap    = in_fire & wr_is_last;
    assign rd_wrap    = out_fire & (rd_cnt_q == LAST);
    assign wr_addr    = bitrev(wr_cnt_q);

    assign out_data   = out_valid ? mem_q[rd_bank_q][rd_cnt_q] : '0;
    assign out_index  = rd_cnt_q;
    assign out_last   = out_valid & (rd_cnt_q == LAST);
    assign frame_err  = frame_err_q;

    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        frame_err_d = frame_err_q;

        // Counters wrap on their own since N is a power of two.
        if (in_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (in_last != wr_is_last) begin
                frame_err_d = 1'b1;
            end
        end

        if (wr_wrap) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end

        if (out_fire) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end

        // A write can only complete into an empty bank and a read can
        // only drain a full one, so the two updates never collide.
        if (rd_wrap) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[wr_bank_q][wr_addr] <= in_data;
        end
    end

endmodule

// File: tb/tb_output_reorder.sv
// tb_output_reorder: randomized self-checking bench for output_reorder.
// Frames are modelled as natural-order arrays sent in bit-reversed order.

module tb_output_reorder;

    import output_reorder_pkg::*;

    localparam int N     = 16;
    localparam int LOG2N = 4;

    typedef struct {
        complex_t d;
        logic     last;
    } beat_t;

    typedef struct {
        complex_t         d;
        logic [LOG2N-1:0] idx;
        logic             last;
    } obs_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    complex_t         in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    complex_t         out_data;
    logic [LOG2N-1:0] out_index;
    logic             out_last;
    logic             frame_err;

    always #5 clk = ~clk;

    output_reorder #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    beat_t    src[$];
    complex_t exp_q[$];
    obs_t     obs[$];

    int n_cmp = 0;
    int n_mis = 0;
    int n_acc = 0;
    int rmode = 1;

    logic             s_ir, s_ov, s_ol, s_or, s_fe, s_fin, s_fout;
    complex_t         s_od;
    logic [LOG2N-1:0] s_oi;

    function automatic int rev(input int x);
        int r = 0;
        int v = x;
        for (int b = 0; b < LOG2N; b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    // mode 0: r=base+j, i=-(base+j); 1: random i; 2: fully random.
    task automatic add_frame(input int mode, input int base,
                             input int last_beat);
        complex_t nat [N];
        for (int j = 0; j < N; j++) begin
            nat[j].r = DW'(base + j);
            nat[j].i = DW'(-(base + j));
            if (mode != 0) nat[j].i = DW'($urandom);
            if (mode == 2) nat[j].r = DW'($urandom);
            exp_q.push_back(nat[j]);
        end
        for (int k = 0; k < N; k++) begin
            beat_t b;
            b.d    = nat[rev(k)];
            b.last = (k == last_beat);
            src.push_back(b);
        end
    endtask

    // One clock: drive after the edge, sample at the falling edge.
    task automatic tick();
        beat_t dummy;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        if (src.size() != 0) begin
            in_valid = 1'b1;
            in_data  = src[0].d;
            in_last  = src[0].last;
        end
        if (rmode == 2) out_ready = ($urandom_range(0, 1) == 1);
        else            out_ready = (rmode == 1);
        @(negedge clk);
        s_ir   = in_ready;
        s_ov   = out_valid;
        s_od   = out_data;
        s_oi   = out_index;
        s_ol   = out_last;
        s_or   = out_ready;
        s_fe   = frame_err;
        s_fin  = in_valid && in_ready;
        s_fout = out_valid && out_ready;
        if (s_fin) begin
            dummy = src.pop_front();
            n_acc++;
        end
        if (s_fout) begin
            obs_t o;
            o.d    = out_data;
            o.idx  = out_index;
            o.last = out_last;
            obs.push_back(o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        src.delete();
        exp_q.delete();
        obs.delete();
        n_acc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #7;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_data !== '0) begin
            n_mis++;
            $display("FAIL reset_out_data got %h want 0", out_data);
        end
        n_cmp++;
        if (out_index !== '0) begin
            n_mis++;
            $display("FAIL reset_out_index got %0d want 0", out_index);
        end
        n_cmp++;
        if (out_last !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_out_last got %b want 0", out_last);
        end
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_frame_err got %b want 0", frame_err);
        end
        apply_reset();
    endtask

    task automatic test_single_frame();
        int early = 0;
        apply_reset();
        rmode = 1;
        add_frame(0, 0, N - 1);
        for (int c = 0; c < 40 && n_acc < N; c++) begin
            tick();
            if (s_ov) early++;
        end
        n_cmp++;
        if (n_acc != N || early != 0) begin
            n_mis++;
            $display("FAIL single_latency_pre got acc=%0d early=%0d want acc=%0d early=0",
                     n_acc, early, N);
        end
        tick();
        n_cmp++;
        if (s_ov !== 1'b1) begin
            n_mis++;
            $display("FAIL single_latency got out_valid=%b want 1", s_ov);
        end
        for (int c = 0; c < 60 && obs.size() < N; c++) tick();
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL single_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && j < obs.size(); j++) begin
            n_cmp++;
            if (obs[j].d !== exp_q[j] || obs[j].idx !== LOG2N'(j % N) ||
                obs[j].last !== (j % N == N - 1)) begin
                n_mis++;
                $display("FAIL single_beat %0d got r=%0d i=%0d idx=%0d last=%b want r=%0d i=%0d idx=%0d last=%b",
                         j, obs[j].d.r, obs[j].d.i, obs[j].idx, obs[j].last,
                         exp_q[j].r, exp_q[j].i, j % N, (j % N == N - 1));
            end
        end
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_mis++;
            $display("FAIL single_frame_err got %b want 0", frame_err);
        end
    endtask

    task automatic test_streaming();
        int drops = 0;
        int gaps = 0;
        bit started = 0;
        apply_reset();
        rmode = 1;
        for (int f = 0; f < 4; f++) add_frame(1, 16 * f, N - 1);
        for (int c = 0; c < 200 && obs.size() < 4 * N; c++) begin
            tick();
            if (in_valid && !s_ir) drops++;
            if (s_ov) started = 1;
            else if (started) gaps++;
        end
        n_cmp++;
        if (drops != 0) begin
            n_mis++;
            $display("FAIL stream_in_ready got %0d low cycles want 0", drops);
        end
        n_cmp++;
        if (gaps != 0) begin
            n_mis++;
            $display("FAIL stream_gaps got %0d idle cycles want 0", gaps);
        end
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL stream_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && j < obs.size(); j++) begin
            n_cmp++;
            if (obs[j].d !== exp_q[j] || obs[j].idx !== LOG2N'(j % N) ||
                obs[j].last !== (j % N == N - 1)) begin
                n_mis++;
                $display("FAIL stream_beat %0d got r=%0d i=%0d idx=%0d last=%b want r=%0d i=%0d idx=%0d last=%b",
                         j, obs[j].d.r, obs[j].d.i, obs[j].idx, obs[j].last,
                         exp_q[j].r, exp_q[j].i, j % N, (j % N == N - 1));
            end
        end
    endtask

    task automatic test_backpressure();
        logic             p_ov, p_or;
        complex_t         p_od;
        logic [LOG2N-1:0] p_oi;
        apply_reset();
        rmode = 0;
        for (int f = 0; f < 3; f++) add_frame(2, 0, N - 1);
        for (int c = 0; c < 40; c++) tick();
        n_cmp++;
        if (n_acc != 2 * N || s_ir !== 1'b0) begin
            n_mis++;
            $display("FAIL bp_accept got acc=%0d in_ready=%b want acc=%0d in_ready=0",
                     n_acc, s_ir, 2 * N);
        end
        rmode = 2;
        p_ov = s_ov;
        p_or = s_or;
        p_od = s_od;
        p_oi = s_oi;
        for (int c = 0; c < 600 && obs.size() < 3 * N; c++) begin
            tick();
            if (p_ov && !p_or) begin
                n_cmp++;
                if (s_ov !== 1'b1 || s_od !== p_od || s_oi !== p_oi) begin
                    n_mis++;
                    $display("FAIL bp_stable got v=%b d=%h idx=%0d want v=1 d=%h idx=%0d",
                             s_ov, s_od, s_oi, p_od, p_oi);
                end
            end
            p_ov = s_ov;
            p_or = s_or;
            p_od = s_od;
            p_oi = s_oi;
        end
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL bp_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && j < obs.size(); j++) begin
            n_cmp++;
            if (obs[j].d !== exp_q[j] || obs[j].idx !== LOG2N'(j % N) ||
                obs[j].last !== (j % N == N - 1)) begin
                n_mis++;
                $display("FAIL bp_beat %0d got r=%0d i=%0d idx=%0d want r=%0d i=%0d idx=%0d",
                         j, obs[j].d.r, obs[j].d.i, obs[j].idx,
                         exp_q[j].r, exp_q[j].i, j % N);
            end
        end
    endtask

    task automatic test_framing_err();
        apply_reset();
        rmode = 1;
        add_frame(2, 0, 7);
        for (int c = 0; c < 30 && n_acc < 8; c++) tick();
        n_cmp++;
        if (s_fe !== 1'b0 || frame_err !== 1'b1) begin
            n_mis++;
            $display("FAIL ferr_early got before=%b after=%b want before=0 after=1",
                     s_fe, frame_err);
        end
        for (int c = 0; c < 60 && obs.size() < N; c++) tick();
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL ferr_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && j < obs.size(); j++) begin
            n_cmp++;
            if (obs[j].d !== exp_q[j] || obs[j].idx !== LOG2N'(j)) begin
                n_mis++;
                $display("FAIL ferr_beat %0d got r=%0d i=%0d idx=%0d want r=%0d i=%0d idx=%0d",
                         j, obs[j].d.r, obs[j].d.i, obs[j].idx,
                         exp_q[j].r, exp_q[j].i, j);
            end
        end
        apply_reset();
        add_frame(2, 0, -1);
        for (int c = 0; c < 30 && n_acc < N; c++) tick();
        n_cmp++;
        if (s_fe !== 1'b0 || frame_err !== 1'b1) begin
            n_mis++;
            $display("FAIL ferr_missing got before=%b after=%b want before=0 after=1",
                     s_fe, frame_err);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rmode = 1;
        add_frame(2, 0, N - 1);
        add_frame(2, 0, N - 1);
        for (int c = 0; c < 60 && n_acc < N + 9; c++) tick();
        n_cmp++;
        if (obs.size() != 9 || out_valid !== 1'b1) begin
            n_mis++;
            $display("FAIL rmid_pre got read=%0d v=%b want read=9 v=1",
                     obs.size(), out_valid);
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
            out_index !== '0 || out_last !== 1'b0 || frame_err !== 1'b0) begin
            n_mis++;
            $display("FAIL rmid_async got rdy=%b v=%b d=%h idx=%0d last=%b err=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, out_data, out_index, out_last, frame_err);
        end
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        src.delete();
        exp_q.delete();
        obs.delete();
        n_acc = 0;
        add_frame(2, 0, N - 1);
        for (int c = 0; c < 80 && obs.size() < N; c++) tick();
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL rmid_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && j < obs.size(); j++) begin
            n_cmp++;
            if (obs[j].d !== exp_q[j] || obs[j].idx !== LOG2N'(j)) begin
                n_mis++;
                $display("FAIL rmid_beat %0d got r=%0d i=%0d idx=%0d want r=%0d i=%0d idx=%0d",
                         j, obs[j].d.r, obs[j].d.i, obs[j].idx,
                         exp_q[j].r, exp_q[j].i, j);
            end
        end
    endtask

    task automatic test_bank_release();
        bit found = 0;
        apply_reset();
        rmode = 0;
        for (int f = 0; f < 3; f++) add_frame(2, 0, N - 1);
        for (int c = 0; c < 40; c++) tick();
        rmode = 1;
        for (int c = 0; c < 60 && !found; c++) begin
            tick();
            if (s_fout && obs.size() == N) found = 1;
        end
        n_cmp++;
        if (!found || s_ir !== 1'b0) begin
            n_mis++;
            $display("FAIL release_same got found=%0d in_ready=%b want found=1 in_ready=0",
                     found, s_ir);
        end
        tick();
        n_cmp++;
        if (s_ir !== 1'b1) begin
            n_mis++;
            $display("FAIL release_next got in_ready=%b want 1", s_ir);
        end
        for (int c = 0; c < 200 && obs.size() < 3 * N; c++) tick();
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL release_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && j < obs.size(); j++) begin
            n_cmp++;
            if (obs[j].d !== exp_q[j] || obs[j].idx !== LOG2N'(j % N)) begin
                n_mis++;
                $display("FAIL release_beat %0d got r=%0d i=%0d idx=%0d want r=%0d i=%0d idx=%0d",
                         j, obs[j].d.r, obs[j].d.i, obs[j].idx,
                         exp_q[j].r, exp_q[j].i, j % N);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_streaming();
        test_backpressure();
        test_framing_err();
        test_reset_mid();
        test_bank_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
